// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the dmem_hs_ram data memory.
//   - rw_type encodings (RW_B, RW_H, RW_W, RW_BU, RW_HU)
//   - FSM state enum
//   - illegal_type(): flags access types that can never be serviced
package dmem_pkg;

  localparam logic [2:0] RW_B  = 3'b000;
  localparam logic [2:0] RW_H  = 3'b001;
  localparam logic [2:0] RW_W  = 3'b010;
  localparam logic [2:0] RW_BU = 3'b100;
  localparam logic [2:0] RW_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Reserved encodings, plus unsigned types on a store (the extension
  // choice is meaningless for writes, so those encodings are rejected).
  function automatic logic illegal_type(input logic we, input logic [2:0] rw_type);
    logic bad;
    bad = (rw_type == 3'b011) || (rw_type == 3'b110) || (rw_type == 3'b111);
    return bad || (we && rw_type[2]);
  endfunction

endpackage

// File: rtl/dmem_hs_ram_if.sv
// dmem_hs_ram_if: request/response handshake bundle for dmem_hs_ram.
//   req_valid/req_ready  request handshake (master -> slave)
//   req_we, req_type, req_addr, req_wdata  request payload
//   rsp_valid/rsp_ready  response handshake (slave -> master)
//   rsp_rdata, rsp_err   response payload
// modport master: core/LSU side; modport slave: memory side.
interface dmem_hs_ram_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_type, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_type, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit: combinational byte-lane logic for dmem_hs_ram.
// Ports:
//   rw_type    in  3   access type
//   addr_lo    in  2   byte offset within the word
//   wdata      in  32  right-aligned store data
//   rdata_word in  32  raw storage word
//   strb       out 4   byte write strobes
//   wdata_rep  out 32  store data replicated across lanes
//   rdata_ext  out 32  extracted, sign/zero-extended load data
//   misalign   out 1   halfword/word access not naturally aligned
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [2:0]  rw_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    strb      = 4'b0000;
    wdata_rep = wdata;
    case (rw_type[1:0])
      2'b00: begin
        strb      = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb      = 4'b0011 << {addr_lo[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      2'b10: begin
        strb      = 4'b1111;
        wdata_rep = wdata;
      end
      default: begin
        strb      = 4'b0000;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    sel_byte  = rdata_word[{addr_lo, 3'b000} +: 8];
    sel_half  = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];
    rdata_ext = 32'h0;
    case (rw_type)
      RW_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      RW_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
      RW_W:    rdata_ext = rdata_word;
      RW_BU:   rdata_ext = {24'h0, sel_byte};
      RW_HU:   rdata_ext = {16'h0, sel_half};
      default: rdata_ext = 32'h0;
    endcase
  end

  assign misalign = ((rw_type[1:0] == 2'b01) && addr_lo[0]) ||
                    ((rw_type == RW_W) && (addr_lo != 2'b00));

endmodule

// File: rtl/dmem_hs_ram.sv
// dmem_hs_ram: RV32 data memory with valid/ready request and response
// channels, programmable wait states, byte-strobe writes and registered,
// extended read data.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of dmem_hs_ram_if (request/response channels)
// Parameters: DEPTH (words, power of two >= 4), WAIT_CYCLES (0..15).
// Optional: define DMEM_BOUNDS_CHK_EN to fault addresses >= DEPTH*4
// instead of aliasing them into storage.
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a request
// WAIT    | request latched, counting down wait states
// RESP    | response presented, held until rsp_ready
module dmem_hs_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_hs_ram_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        we_q;
  logic [2:0]  type_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        go_resp;
  logic        cur_we;
  logic [2:0]  cur_type;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [IDX_W-1:0] cur_idx;
  logic        oob;
  logic        acc_err;
  logic        mem_we;

  logic [3:0]  strb;
  logic [31:0] wdata_rep;
  logic [31:0] rdata_ext;
  logic        misalign;
  logic        unused_addr_hi;

  assign accept = (state == ST_IDLE) && bus.req_valid && bus.req_ready;

  // With no wait states the access happens on the accept edge itself, so the
  // lane logic must see the live request while IDLE and the latched copy later.
  always_comb begin
    if (state == ST_IDLE) begin
      cur_we    = bus.req_we;
      cur_type  = bus.req_type;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
    end else begin
      cur_we    = we_q;
      cur_type  = type_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
  end

  assign go_resp = (state == ST_IDLE) ? (accept && (WAIT_CYCLES == 0))
                                      : ((state == ST_WAIT) && (wait_cnt == 4'd0));

  assign cur_idx        = cur_addr[IDX_W+1:2];
  assign unused_addr_hi = ^cur_addr[31:IDX_W+2];

`ifdef DMEM_BOUNDS_CHK_EN
  assign oob = (cur_addr >= 32'(DEPTH * 4));
`else
  assign oob = 1'b0;
`endif

  assign acc_err = illegal_type(cur_we, cur_type) || misalign || oob;
  // rst_n gating keeps a request presented during reset from writing.
  assign mem_we  = go_resp && cur_we && !acc_err && rst_n;

  dmem_lane_unit u_lane (
    .rw_type    (cur_type),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .rdata_word (mem[cur_idx]),
    .strb       (strb),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misalign   (misalign)
  );

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (strb[i]) mem[cur_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      wait_cnt      <= 4'd0;
      we_q          <= 1'b0;
      type_q        <= 3'b000;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q          <= bus.req_we;
            type_q        <= bus.req_type;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else begin
              state <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == 4'd0) state <= ST_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state         <= ST_IDLE;
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (go_resp) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= acc_err;
        bus.rsp_rdata <= (acc_err || cur_we) ? 32'h0 : rdata_ext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_hs_ram.sv
// tb_dmem_hs_ram: directed bench for dmem_hs_ram (DEPTH=256, WAIT_CYCLES=2).
module tb_dmem_hs_ram;
  import dmem_pkg::*;

  localparam int TMO = 50;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  dmem_hs_ram_if bus ();

  dmem_hs_ram #(.DEPTH(256), .WAIT_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and completes its response; lat counts cycles from the
  // handshake cycle (0) to the first cycle with rsp_valid.
  task automatic access(input logic we, input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_type  = t;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    n = 0;
    while (!bus.req_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) chk("req_ready_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = 32'hFFFF_FFFF;
    bus.req_addr  = 32'h0000_0003;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < TMO);
    if (lat >= TMO) chk("rsp_valid_timeout", 32'(lat), 32'(0));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] wd,
                       input string tag, input logic exp_err);
    logic [31:0] rd;
    logic er;
    int lat;
    access(1'b1, t, a, wd, rd, er, lat);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] exp,
                      input string tag, input logic exp_err);
    logic [31:0] rd;
    logic er;
    int lat;
    access(1'b0, t, a, 32'h0, rd, er, lat);
    chk({tag, "_err"}, 32'(er), 32'(exp_err));
    chk({tag, "_rdata"}, rd, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] hold_rd;
    logic er;
    logic hold_er;
    int lat;
    int seen_valid;

    checks = 0;
    errors = 0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_type  = RW_W;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'(1));
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
    rst_n = 1'b1;

    // Byte store merge
    store(RW_W, 32'h4, 32'h1122_3344, "sw4", 1'b0);
    store(RW_B, 32'h5, 32'h0000_00AB, "sb5", 1'b0);
    load(RW_W, 32'h4, 32'h1122_AB44, "lw4", 1'b0);

    // Halfword store merge into upper half
    store(RW_H, 32'h6, 32'h0000_5566, "sh6", 1'b0);
    load(RW_W, 32'h4, 32'h5566_AB44, "lw4b", 1'b0);

    // Sign/zero extension
    store(RW_W, 32'h8, 32'h8000_F0FF, "sw8", 1'b0);
    load(RW_B,  32'h8, 32'hFFFF_FFFF, "lb8", 1'b0);
    load(RW_BU, 32'h8, 32'h0000_00FF, "lbu8", 1'b0);
    load(RW_H,  32'hA, 32'hFFFF_8000, "lhA", 1'b0);
    load(RW_HU, 32'hA, 32'h0000_8000, "lhuA", 1'b0);
    load(RW_B,  32'h9, 32'hFFFF_FFF0, "lb9", 1'b0);
    load(RW_BU, 32'hB, 32'h0000_0080, "lbuB", 1'b0);

    // Misalignment and illegal types
    store(RW_W, 32'h10, 32'h0102_0304, "sw10", 1'b0);
    store(RW_W, 32'h12, 32'hDEAD_BEEF, "sw12_mis", 1'b1);
    load(RW_W, 32'h10, 32'h0102_0304, "lw10_keep", 1'b0);
    store(RW_BU, 32'h10, 32'h0000_00EE, "st_t100", 1'b1);
    store(3'b110, 32'h10, 32'h0000_00EE, "st_t110", 1'b1);
    load(RW_W, 32'h10, 32'h0102_0304, "lw10_keep2", 1'b0);
    load(RW_H, 32'h11, 32'h0, "lh11_mis", 1'b1);
    load(3'b011, 32'h10, 32'h0, "ld_t011", 1'b1);

    // Latency: handshake cycle 0, rsp_valid first at cycle WAIT_CYCLES+1
    access(1'b0, RW_W, 32'h8, 32'h0, rd, er, lat);
    chk("latency", 32'(lat), 32'(3));
    chk("latency_rdata", rd, 32'h8000_F0FF);

    // Backpressure
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_type  = RW_W;
    bus.req_addr  = 32'h4;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    seen_valid = 0;
    for (int i = 0; i < TMO && seen_valid == 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_valid = 1;
    end
    chk("bp_rsp_valid", 32'(seen_valid), 32'(1));
    hold_rd = bus.rsp_rdata;
    hold_er = bus.rsp_err;
    chk("bp_rdata", hold_rd, 32'h5566_AB44);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'(1));
      chk("bp_hold_rdata", bus.rsp_rdata, hold_rd);
      chk("bp_hold_err", 32'(bus.rsp_err), 32'(hold_er));
      chk("bp_req_ready", 32'(bus.req_ready), 32'(0));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("bp_release_ready", 32'(bus.req_ready), 32'(1));
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'(0));

    // Reset during WAIT drops a pending store
    store(RW_W, 32'h20, 32'hCAFE_F00D, "sw20", 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_type  = RW_W;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rstw_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    chk("rstw_req_ready", 32'(bus.req_ready), 32'(1));
    seen_valid = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) seen_valid = 1;
    end
    chk("rstw_no_rsp", 32'(seen_valid), 32'(0));
    load(RW_W, 32'h20, 32'hCAFE_F00D, "lw20_keep", 1'b0);

    // Bounds / aliasing
    store(RW_W, 32'h0, 32'h0BAD_C0DE, "sw0", 1'b0);
`ifdef DMEM_BOUNDS_CHK_EN
    load(RW_W, 32'h400, 32'h0, "lw400_oob", 1'b1);
`else
    load(RW_W, 32'h400, 32'h0BAD_C0DE, "lw400_alias", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
